// File: rtl/dec_bin_prio_pkg.sv
// dec_bin_prio_pkg: shared sizing constants for the dec_bin_prio priority encoder
package dec_bin_prio_pkg;
    localparam int N_IN  = 8;
    localparam int N_OUT = 3;
endpackage

// File: rtl/dec_bin_prio_prio_enc8.sv
// prio_enc8: combinational 8-input priority encoder; the highest-numbered asserted request wins
//   i   : request vector, i[k] is request k
//   idx : binary index of the winner, idx[0] is MSB (0 when no request is asserted)
//   any : 1 when at least one request is asserted
module prio_enc8
    import dec_bin_prio_pkg::*;
(
    input  logic [0:N_IN-1]  i,
    output logic [0:N_OUT-1] idx,
    output logic             any
);
    always_comb begin
        idx = '0;
        // ascending scan, so the last (highest) asserted request overwrites lower ones
        for (int k = 0; k < N_IN; k++)
            idx = i[k] ? N_OUT'(k) : idx;
        any = |i;
    end
endmodule

// File: rtl/dec_bin_prio.sv
// dec_bin_prio: registered priority encoder with one clock of latency
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears o and v
//   i   : request vector, i[k] is request k
//   o   : registered index of the highest-numbered asserted request, o[0] is MSB
//   v   : registered valid, 1 when any request was asserted
module dec_bin_prio
    import dec_bin_prio_pkg::*;
#(
    parameter int N_IN  = dec_bin_prio_pkg::N_IN,
    parameter int N_OUT = dec_bin_prio_pkg::N_OUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:N_IN-1]  i,
    output logic [0:N_OUT-1] o,
    output logic             v
);
    logic [0:N_OUT-1] o_d, o_q;
    logic             v_d, v_q;

    prio_enc8 u_enc (
        .i   (i),
        .idx (o_d),
        .any (v_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= '0;
            v_q <= 1'b0;
        end else begin
            o_q <= o_d;
            v_q <= v_d;
        end
    end

    assign o = o_q;
    assign v = v_q;
endmodule

// File: tb/tb_dec_bin_prio.sv
// tb_dec_bin_prio: directed and random checks of dec_bin_prio against hand values and a reference model
module tb_dec_bin_prio;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:7] i   = '0;
    logic [0:2] o;
    logic       v;
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [0:7] bv;
    logic [3:0] exp_ov;

    dec_bin_prio dut (
        .clk (clk),
        .rst (rst),
        .i   (i),
        .o   (o),
        .v   (v)
    );

    always #5 clk = ~clk;

    // returns {v, o}: search downward from the top request
    function automatic logic [3:0] ref_enc(input logic [0:7] x);
        for (int j = 7; j >= 0; j--)
            if (x[j]) return {1'b1, 3'(j)};
        return 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got v=%0b o=%0d, expected v=%0b o=%0d", tag, got[3], got[2:0], exp[3], exp[2:0]);
    endtask

    task automatic step(input logic [0:7] val, input logic r);
        @(negedge clk);
        i   = val;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        chk("reset", {v, o}, 4'b0000);
        step(8'h00, 1'b0);
        chk("idle", {v, o}, 4'b0000);
        bv = '0;
        for (int k = 0; k < 8; k++) begin
            bv[k] = 1'b1;
            step(bv, 1'b0);
            chk($sformatf("cumul%0d", k), {v, o}, {1'b1, 3'(k)});
        end
        step(8'b0000_0100, 1'b0);
        chk("onehot5", {v, o}, 4'b1101);
        step(8'b1000_0000, 1'b0);
        chk("onehot0", {v, o}, 4'b1000);
        step(8'b0010_0010, 1'b0);
        chk("pair2_6", {v, o}, 4'b1110);
        step(8'b0010_0000, 1'b0);
        chk("drop6", {v, o}, 4'b1010);
        step(8'b0000_0001, 1'b0);
        chk("onehot7", {v, o}, 4'b1111);
        step(8'hff, 1'b1);
        chk("rst_mid", {v, o}, 4'b0000);
        step(8'hff, 1'b0);
        chk("rst_rel", {v, o}, 4'b1111);
        step(8'h00, 1'b0);
        chk("back_idle", {v, o}, 4'b0000);
        for (int c = 0; c < 1000; c++) begin
            bv = 8'($urandom);
            if (c % 4 == 0) bv = bv & 8'($urandom);
            exp_ov = ref_enc(bv);
            step(bv, 1'b0);
            chk("rand", {v, o}, exp_ov);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
